// File: rtl/board_stream_pkg.sv
// Shared types and frame constants for the board byte stream.
// The header values must match the TPU grid decoder.
package board_stream_pkg;

   typedef enum logic [2:0] {
      IDLE,
      GRID_HDR,
      GRID,
      MOVE_HDR,
      COUNT,
      MOVES,
      DONE
   } state_e;

   localparam logic [7:0] GRID_HEADER_DEF = 8'b11_01_01_01;
   localparam logic [7:0] MOVE_HEADER_DEF = 8'b11_10_10_10;

   // Header + cells + header + count
   localparam int FRAME_FIXED_BYTES = 67;

endpackage

// File: rtl/board_stream_encoder_serializer.sv
// Splits one move word into stream bytes, most-significant first.
// out_byte is the byte to register next: the load word's top or the shift.
module move_byte_serializer #(
   parameter int MOVE_WIDTH = 16,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  load,
   input  logic                  shift,
   input  logic [MOVE_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] out_byte,
   output logic                  is_last,
   output logic                  is_penult
);

   localparam int BYTES = MOVE_WIDTH / DATA_WIDTH;
   localparam int PW    = $clog2(BYTES);

   logic [MOVE_WIDTH-1:0] sr_q;
   logic [PW-1:0]         pos_q;

   // sr_q holds the bytes not yet handed out, aligned to the top
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sr_q  <= '0;
         pos_q <= '0;
      end else if (load) begin
         sr_q  <= din << DATA_WIDTH;
         pos_q <= '0;
      end else if (shift) begin
         sr_q  <= sr_q << DATA_WIDTH;
         pos_q <= pos_q + PW'(1);
      end
   end

   assign out_byte  = load ? din[MOVE_WIDTH-1 -: DATA_WIDTH]
                           : sr_q[MOVE_WIDTH-1 -: DATA_WIDTH];
   assign is_last   = pos_q == PW'(BYTES-1);
   assign is_penult = pos_q == PW'(BYTES-2);

endmodule

// File: rtl/board_stream_encoder.sv
// Host framer: GRID_HEADER, grid, MOVE_HEADER, count, moves.
// BOARD_STREAM_GAP_EN inserts one idle cycle after every byte.
module board_stream_encoder
   import board_stream_pkg::*;
#(
   parameter int                    WIDTH       = 8,
   parameter int                    HEIGHT      = 8,
   parameter int                    DATA_WIDTH  = 8,
   parameter int                    MOVE_WIDTH  = 16,
   parameter int                    MAX_MOVES   = 220,
   parameter logic [DATA_WIDTH-1:0] GRID_HEADER = GRID_HEADER_DEF,
   parameter logic [DATA_WIDTH-1:0] MOVE_HEADER = MOVE_HEADER_DEF
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic                   start,
   input  logic [HEIGHT-1:0][WIDTH-1:0][DATA_WIDTH-1:0] grid_id,
   input  logic [7:0]             total_move_id,
   output logic                   move_rd_en,
   output logic [7:0]             move_rd_addr,
   input  logic [MOVE_WIDTH-1:0]  move_rd_d,
   output logic                   spi_ov,
   output logic [DATA_WIDTH-1:0]  spi_od,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   localparam int CELLS = WIDTH * HEIGHT;
   localparam int CW    = $clog2(CELLS);
   localparam logic [CW-1:0] CELL_LAST = CW'(CELLS-1);

   state_e state_q, state_d;

   logic [HEIGHT-1:0][WIDTH-1:0][DATA_WIDTH-1:0] grid_q;
   logic [CELLS*DATA_WIDTH-1:0] grid_flat;

   logic [CW-1:0] cell_q, cell_d, cell_nxt;
   logic [7:0]    n_q, move_q, move_d, move_nxt;

   logic                  ov_d, err_d, capture;
   logic [DATA_WIDTH-1:0] od_d, ser_byte;
   logic ser_load, ser_shift, ser_last, ser_penult;
   logic adv, on_byte, has_moves, fetch_ok;
   logic emitting, finish;

   assign grid_flat = grid_q;
   assign cell_nxt  = cell_q + CW'(1);
   assign move_nxt  = move_q + 8'd1;
   assign has_moves = n_q != 8'd0;
   assign fetch_ok  = move_nxt < n_q;
   assign emitting  = state_q inside {GRID_HDR, GRID, MOVE_HDR,
                                      COUNT, MOVES};

   assign busy = state_q != IDLE;
   assign done = state_q == DONE;

   // Last byte of the frame is on the wire: next cycle is DONE
   assign finish = on_byte &&
      ((state_q == COUNT && !has_moves) ||
       (state_q == MOVES && ser_last && !fetch_ok));

`ifdef BOARD_STREAM_GAP_EN
   localparam bit GAP_EN = 1'b1;

   logic hold_q;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) hold_q <= 1'b0;
      else       hold_q <= emitting && !hold_q && !finish;
   end

   assign adv     = hold_q;
   assign on_byte = !hold_q;
`else
   localparam bit GAP_EN = 1'b0;

   assign adv     = 1'b1;
   assign on_byte = 1'b1;
`endif

   move_byte_serializer #(
      .MOVE_WIDTH (MOVE_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ser (
      .clk       (clk),
      .nrst      (nrst),
      .load      (ser_load),
      .shift     (ser_shift),
      .din       (move_rd_d),
      .out_byte  (ser_byte),
      .is_last   (ser_last),
      .is_penult (ser_penult)
   );

   always_comb begin
      state_d      = state_q;
      ov_d         = spi_ov;
      od_d         = spi_od;
      err_d        = 1'b0;
      capture      = 1'b0;
      cell_d       = cell_q;
      move_d       = move_q;
      ser_load     = 1'b0;
      ser_shift    = 1'b0;
      move_rd_en   = 1'b0;
      move_rd_addr = '0;

      if (emitting && !adv) ov_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (total_move_id > 8'(MAX_MOVES)) begin
                  err_d = 1'b1;
               end else begin
                  capture = 1'b1;
                  state_d = GRID_HDR;
                  ov_d    = 1'b1;
                  od_d    = GRID_HEADER;
               end
            end
         end
         GRID_HDR: begin
            if (adv) begin
               state_d = GRID;
               cell_d  = '0;
               ov_d    = 1'b1;
               od_d    = grid_flat[DATA_WIDTH-1:0];
            end
         end
         GRID: begin
            if (adv) begin
               ov_d = 1'b1;
               if (cell_q == CELL_LAST) begin
                  state_d = MOVE_HDR;
                  od_d    = MOVE_HEADER;
               end else begin
                  cell_d = cell_nxt;
                  od_d   = grid_flat[cell_nxt*DATA_WIDTH +: DATA_WIDTH];
               end
            end
         end
         MOVE_HDR: begin
            move_rd_en = !GAP_EN && has_moves;
            if (adv) begin
               state_d = COUNT;
               ov_d    = 1'b1;
               od_d    = DATA_WIDTH'(n_q);
            end
         end
         COUNT: begin
            move_rd_en = GAP_EN && on_byte && has_moves;
            if (finish) begin
               state_d = DONE;
               ov_d    = 1'b0;
            end else if (adv) begin
               state_d  = MOVES;
               ov_d     = 1'b1;
               ser_load = 1'b1;
               od_d     = ser_byte;
               move_d   = '0;
            end
         end
         MOVES: begin
            // Prefetch lands in the cycle the current word runs out
            if (fetch_ok && (GAP_EN ? (on_byte && ser_last)
                                    : ser_penult)) begin
               move_rd_en   = 1'b1;
               move_rd_addr = move_nxt;
            end
            if (finish) begin
               state_d = DONE;
               ov_d    = 1'b0;
            end else if (adv) begin
               ov_d = 1'b1;
               od_d = ser_byte;
               if (ser_last) begin
                  ser_load = 1'b1;
                  move_d   = move_nxt;
               end else begin
                  ser_shift = 1'b1;
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
         spi_ov  <= 1'b0;
         spi_od  <= '0;
         err     <= 1'b0;
         cell_q  <= '0;
         move_q  <= '0;
         n_q     <= '0;
         grid_q  <= '0;
      end else begin
         state_q <= state_d;
         spi_ov  <= ov_d;
         spi_od  <= od_d;
         err     <= err_d;
         cell_q  <= cell_d;
         move_q  <= move_d;
         if (capture) begin
            grid_q <= grid_id;
            n_q    <= total_move_id;
         end
      end
   end

endmodule

// File: tb/tb_board_stream_encoder.sv
// Scoreboard bench for board_stream_encoder: frames, reads, done, err.
// Follows BOARD_STREAM_GAP_EN when the same macro is set for the bench.
module tb_board_stream_encoder;

`ifdef BOARD_STREAM_GAP_EN
   localparam bit GAP = 1'b1;
`else
   localparam bit GAP = 1'b0;
`endif

   logic clk = 1'b0;
   logic nrst = 1'b0;
   logic start = 1'b0;
   logic [7:0][7:0][7:0] grid_id = '0;
   logic [7:0]  total_move_id = '0;
   logic        move_rd_en;
   logic [7:0]  move_rd_addr;
   logic [15:0] move_rd_d = '0;
   logic        spi_ov;
   logic [7:0]  spi_od;
   logic        busy, done, err;

   always #5 clk = ~clk;

   board_stream_encoder dut (
      .clk           (clk),
      .nrst          (nrst),
      .start         (start),
      .grid_id       (grid_id),
      .total_move_id (total_move_id),
      .move_rd_en    (move_rd_en),
      .move_rd_addr  (move_rd_addr),
      .move_rd_d     (move_rd_d),
      .spi_ov        (spi_ov),
      .spi_od        (spi_od),
      .busy          (busy),
      .done          (done),
      .err           (err)
   );

   logic [15:0] mem [256];

   // Synchronous move memory; junk when not read
   always @(posedge clk)
      move_rd_d <= move_rd_en ? mem[move_rd_addr] : 16'hDEAD;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int c;
      int v;
   } exp_t;

   exp_t bq[$];
   exp_t rq[$];
   int   dq[$];

   int checks = 0;
   int passed = 0;
   int t0 = 0;
   int t0b = 0;

   function automatic void chk(string n, int a, int e);
      checks++;
      if (a == e) passed++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) cyc %0d",
                    n, a, a, e, e, cyc);
   endfunction

   function automatic logic [7:0] pat(int sel, int i);
      logic [7:0] v;
      v = 8'(i);
      if (sel != 0) v = 8'hFF ^ 8'(i * 3);
      return v;
   endfunction

   function automatic int bcyc(int base, int i);
      return GAP ? base + 2*i + 1 : base + i + 1;
   endfunction

   function automatic int done_rel(int n);
      return bcyc(0, 66 + 2*n) + 1;
   endfunction

   function automatic void push_frame(int base, int n, int sel);
      logic [15:0] w;
      bq.push_back('{bcyc(base, 0), 8'hD5});
      for (int i = 0; i < 64; i++)
         bq.push_back('{bcyc(base, 1 + i), int'(pat(sel, i))});
      bq.push_back('{bcyc(base, 65), 8'hEA});
      bq.push_back('{bcyc(base, 66), n});
      for (int k = 0; k < n; k++) begin
         w = mem[k];
         bq.push_back('{bcyc(base, 67 + 2*k), int'(w[15:8])});
         bq.push_back('{bcyc(base, 68 + 2*k), int'(w[7:0])});
         rq.push_back('{GAP ? bcyc(base, 66 + 2*k)
                            : bcyc(base, 65 + 2*k), k});
      end
      dq.push_back(base + done_rel(n));
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (nrst) begin
         if (spi_ov) begin
            if (bq.size() == 0) chk("unexpected_byte", spi_od, -1);
            else begin
               e = bq.pop_front();
               chk("byte_value", spi_od, e.v);
               chk("byte_cycle", cyc, e.c);
               chk("busy_with_byte", busy, 1);
            end
         end
         if (move_rd_en) begin
            if (rq.size() == 0) chk("unexpected_read", move_rd_addr, -1);
            else begin
               e = rq.pop_front();
               chk("read_addr", move_rd_addr, e.v);
               chk("read_cycle", cyc, e.c);
            end
         end
         if (done) begin
            if (dq.size() == 0) chk("unexpected_done", cyc, -1);
            else begin
               chk("done_cycle", cyc, dq.pop_front());
               chk("busy_at_done", busy, 1);
            end
         end
      end
   end

   task automatic launch(input logic [7:0] n, input int sel,
                         input bit keep, output int tz);
      @(negedge clk);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            grid_id[r][c] = pat(sel, r*8 + c);
      total_move_id = n;
      start = 1'b1;
      tz = cyc;
      if (n <= 8'd220) push_frame(tz, int'(n), sel);
      @(negedge clk);
      if (!keep) start = 1'b0;
   endtask

   task automatic drain(input int budget);
      int w;
      w = 0;
      while ((bq.size() != 0 || rq.size() != 0 || dq.size() != 0 || busy)
             && w < budget) begin
         @(negedge clk);
         w++;
      end
      chk("drain_in_budget", int'(w < budget), 1);
      chk("queues_empty", bq.size() + rq.size() + dq.size(), 0);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < 256; k++) mem[k] = {8'(k), ~8'(k)};
      mem[0] = 16'h1234;
      mem[1] = 16'hABCD;
      mem[2] = 16'h0F0F;

      #12;
      chk("rst_spi_ov", spi_ov, 0);
      chk("rst_spi_od", spi_od, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_rd_en", move_rd_en, 0);
      chk("rst_rd_addr", move_rd_addr, 0);
      @(negedge clk);
      nrst = 1'b1;
      repeat (2) @(negedge clk);

      launch(8'd0, 0, 1'b0, t0);
      drain(2000);

      launch(8'd3, 1, 1'b0, t0);
      drain(2000);

      launch(8'd221, 0, 1'b0, t0);
      chk("err_pulse", err, 1);
      chk("err_busy", busy, 0);
      chk("err_spi_ov", spi_ov, 0);
      @(negedge clk);
      chk("err_cleared", err, 0);
      chk("err_busy_after", busy, 0);
      repeat (5) @(negedge clk);

      launch(8'd220, 1, 1'b0, t0);
      drain(5000);

      launch(8'd0, 0, 1'b1, t0);
      t0b = t0 + done_rel(0) + 1;
      push_frame(t0b, 0, 0);
      while (cyc < t0b + 1 && cyc < t0 + 1000) @(negedge clk);
      start = 1'b0;
      drain(2000);

      launch(8'd5, 1, 1'b0, t0);
      while (cyc < t0 + 40) @(negedge clk);
      nrst = 1'b0;
      #1;
      chk("abort_spi_ov", spi_ov, 0);
      chk("abort_spi_od", spi_od, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_err", err, 0);
      chk("abort_rd_en", move_rd_en, 0);
      chk("abort_rd_addr", move_rd_addr, 0);
      bq.delete();
      rq.delete();
      dq.delete();
      repeat (3) @(negedge clk);
      nrst = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_abort_idle", busy, 0);
      launch(8'd1, 0, 1'b0, t0);
      drain(2000);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/board_stream_encoder.md
# board_stream_encoder

Host-side transmitter for the TPU's byte-wide SPI input stream. On a start pulse it snapshots an 8x8 board and a move count, then emits the framed stream GRID_HEADER, 64 grid bytes, MOVE_HEADER, move count and every move (MSB byte first), fetched from an external move memory. It drives the `spi_iv`/`spi_id` pair that the TPU's grid decoder consumes, and is used in board-level test harnesses and the host FPGA bridge.

## Interface
- WIDTH, 8, board columns
- HEIGHT, 8, board rows
- DATA_WIDTH, 8, bits per cell and per stream byte
- MOVE_WIDTH, 16, bits per move; must be a multiple of DATA_WIDTH and at least 2*DATA_WIDTH
- MAX_MOVES, 220, largest legal move count
- GRID_HEADER, 8'b11_01_01_01, grid frame marker
- MOVE_HEADER, 8'b11_10_10_10, move frame marker

Ports:
- clk  in  1  single clock, rising edge
- nrst  in  1  asynchronous active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- grid_id  in  HEIGHT*WIDTH*DATA_WIDTH  board, packed [HEIGHT-1:0][WIDTH-1:0][DATA_WIDTH-1:0]; sampled with start
- total_move_id  in  8  move count N; sampled with start
- move_rd_en  out  1  move memory read strobe (combinational from state)
- move_rd_addr  out  8  move index
- move_rd_d  in  MOVE_WIDTH  read data, valid exactly one cycle after move_rd_en
- spi_ov  out  1  byte valid (registered)
- spi_od  out  DATA_WIDTH  byte (registered)
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last byte
- err  out  1  one-cycle pulse on a rejected start

## Operation
- States: IDLE, GRID_HDR, GRID, MOVE_HDR, COUNT, MOVES, DONE.
- IDLE with start=1 and N<=MAX_MOVES: capture grid_id and N. At the same edge, load spi_od<=GRID_HEADER and spi_ov<=1.
- IDLE with start=1 and N>MAX_MOVES: pulse err, stay IDLE, no bytes emitted.
- start outside IDLE is ignored.
- Grid byte order: row-major, row 0 col 0 first. Cell [r][c] is byte 1+r*WIDTH+c of the frame.
- Moves are sent as B=MOVE_WIDTH/DATA_WIDTH bytes each, most-significant byte first, index 0..N-1.
- Prefetch rule: read move k+1 in the cycle where byte B-2 of the current item is on spi_od.
  - For move 0, the "current item" is the MOVE_HEADER/count pair.
  - No read is issued when N=0 or after the last move.
- Captured read data goes into a shift register. spi_od takes its top byte.
- Move counter is 8 bits; move_rd_addr equals the index being fetched.

## Timing
- Reset (async): spi_ov=0, spi_od=0, busy=0, done=0, err=0, move_rd_en=0, move_rd_addr=0, state IDLE. Reset mid-frame aborts immediately; no done pulse follows.
- Let cycle 0 be the start edge. Without the gap feature:
  - frame bytes appear contiguously in cycles 1..67+B*N;
  - done=1 in cycle 68+B*N;
  - busy=1 from cycle 1 through the done cycle;
  - a new start is accepted in the cycle after done.
- First move read (B=2): move_rd_en in cycle 66 (MOVE_HEADER on output), data in cycle 67, byte 0 on output in cycle 68.
- N=0: bytes in cycles 1..67, done in cycle 68, move_rd_en never asserted.

## Configuration
- BOARD_STREAM_GAP_EN defined: one spi_ov=0 cycle follows every byte.
  - Byte i of the frame (0-based) appears in cycle 2i+1.
  - Prefetch moves to the cycle where the last byte of the current item is on output.
  - done pulses the cycle after the final byte.
- Not defined: contiguous stream as above.

## Structure
- Package board_stream_pkg holds:
  - state enum;
  - default GRID_HEADER/MOVE_HEADER constants, shared with the decoder side;
  - FRAME_FIXED_BYTES=67.
- Sub-module move_byte_serializer: parallel load of MOVE_WIDTH bits, shift out DATA_WIDTH per step, last-byte and penultimate-byte flags.

## Test plan
- Grid cells [r][c]=r*8+c, N=0 -> 67 bytes: 0xD5, 0x00..0x3F, 0xEA, 0x00; done in cycle 68; no move_rd_en.
- N=3, memory {0x1234, 0xABCD, 0x0F0F} -> after the count byte 0x03: 12 34 AB CD 0F 0F contiguous; reads at addresses 0,1,2 each exactly two cycles before their first byte; done in cycle 74.
- N=221 -> err pulse, spi_ov stays 0, busy stays 0; N=220 accepted, done in cycle 508.
- start held high through a whole frame -> exactly one frame; second frame begins the cycle after done.
- nrst asserted in cycle 40 -> all outputs 0 asynchronously; no done. Fresh start after release -> complete frame.
- With BOARD_STREAM_GAP_EN, N=1 -> spi_ov alternates 1/0; byte i in cycle 2i+1; done in cycle 138.
